// File: rtl/thrsched_ctl_if.sv
// thrsched_ctl_if: bundle between the IFU thread-select stage and the thread
// scheduler/controller.
//   Requests toward the scheduler: thr_en, wait-mask set/clear strobes
//   (imiss, other, stb), speculative wake/complete/kill, switch_req, stallreq.
//   Results from the scheduler: registered wait masks, per-thread one-hot
//   FSM states, one-hot running thread, its valid, and completion pulses.
// The scheduler attaches through the slave modport; the stage driving it
// (or a testbench) uses master.
interface thrsched_ctl_if;
  logic [3:0] thr_en;
  logic [3:0] wm_imiss_set;
  logic [3:0] wm_imiss_clr;
  logic [3:0] wm_other_set;
  logic [3:0] wm_other_clr;
  logic [3:0] wm_stb_set;
  logic [3:0] wm_stb_clr;
  logic [3:0] spec_wake;
  logic [3:0] spec_cmpl;
  logic [3:0] spec_kill;
  logic       switch_req;
  logic       stallreq;

  logic [3:0] wm_imiss;
  logic [3:0] wm_other;
  logic [3:0] wm_stbwait;
  logic [4:0] thr_state0;
  logic [4:0] thr_state1;
  logic [4:0] thr_state2;
  logic [4:0] thr_state3;
  logic [3:0] thr_sel;
  logic       thr_sel_vld;
  logic [3:0] completion;

  modport master (
    output thr_en, wm_imiss_set, wm_imiss_clr, wm_other_set, wm_other_clr,
           wm_stb_set, wm_stb_clr, spec_wake, spec_cmpl, spec_kill,
           switch_req, stallreq,
    input  wm_imiss, wm_other, wm_stbwait, thr_state0, thr_state1,
           thr_state2, thr_state3, thr_sel, thr_sel_vld, completion
  );

  modport slave (
    input  thr_en, wm_imiss_set, wm_imiss_clr, wm_other_set, wm_other_clr,
           wm_stb_set, wm_stb_clr, spec_wake, spec_cmpl, spec_kill,
           switch_req, stallreq,
    output wm_imiss, wm_other, wm_stbwait, thr_state0, thr_state1,
           thr_state2, thr_state3, thr_sel, thr_sel_vld, completion
  );
endinterface

// File: rtl/thrsched_ctl.sv
// thrsched_ctl: four-thread scheduler for the IFU thread-select stage.
// Owns the per-thread wait masks (imiss, other, stbwait) and the one-hot
// five-state per-thread FSM (WAIT/RDY/SPEC_RDY/RUN/SPEC_RUN), and picks at
// most one thread per cycle to run, round-robin, preferring non-speculative
// ready threads over speculatively woken ones.
// Ports:
//   clk  - core clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - thrsched_ctl_if.slave: requests in, registered masks/states/
//          selection/completion out
module thrsched_ctl (
  input  logic                 clk,
  input  logic                 rst,
  thrsched_ctl_if.slave        bus
);

  typedef enum logic [4:0] {
    ST_WAIT     = 5'b00001,
    ST_RDY      = 5'b00010,
    ST_SPEC_RDY = 5'b00100,
    ST_RUN      = 5'b01000,
    ST_SPEC_RUN = 5'b10000
  } state_e;

  function automatic logic is_spec(state_e s);
    return (s == ST_SPEC_RDY) || (s == ST_SPEC_RUN);
  endfunction

  function automatic logic is_run(state_e s);
    return (s == ST_RUN) || (s == ST_SPEC_RUN);
  endfunction

  logic [3:0] imiss_q, imiss_d;
  logic [3:0] other_q, other_d;
  logic [3:0] stb_q,   stb_d;
  logic [3:0] comp_q,  comp_d;
  logic [3:0] sel_q,   sel_d;
  logic [1:0] last_q,  last_d;
  state_e     state_q [4];
  state_e     state_d [4];

  // Post wait-mask / speculation state, before the selection result
  state_e     st_m [4];

  logic [3:0] imiss_n, other_n, stb_n, set_pend;
  logic [3:0] wake_ok, kill_ok;

  logic       run_any, keep, found;
  logic [1:0] run_idx, pick, idx;
  logic [3:0] cand_rdy, cand_spec;

  // Wait masks and FSM rules that do not depend on selection
  always_comb begin
    imiss_n  = (imiss_q & ~bus.wm_imiss_clr) | bus.wm_imiss_set;
    other_n  = (other_q & ~bus.wm_other_clr) | bus.wm_other_set;
    stb_n    = (stb_q   & ~bus.wm_stb_clr)   | bus.wm_stb_set;
    set_pend = bus.wm_imiss_set | bus.wm_other_set | bus.wm_stb_set;
    wake_ok  = '0;
    kill_ok  = '0;
    comp_d   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      st_m[i] = state_q[i];
      // A valid speculative wake consumes the only pending bit (other), so
      // it is tested ahead of the any-bit-set check that would force WAIT.
      wake_ok[i] = bus.spec_wake[i] && (state_q[i] == ST_WAIT) &&
                   other_n[i] && !imiss_n[i] && !stb_n[i] && !set_pend[i];
      if (wake_ok[i]) begin
        st_m[i] = ST_SPEC_RDY;
      end else if (imiss_n[i] || other_n[i] || stb_n[i]) begin
        st_m[i] = ST_WAIT;
      end else if (bus.spec_kill[i] && is_spec(state_q[i])) begin
        st_m[i]    = ST_WAIT;
        kill_ok[i] = 1'b1;
      end else if (state_q[i] == ST_WAIT) begin
        st_m[i]   = ST_RDY;
        comp_d[i] = 1'b1;
      end else if (bus.spec_cmpl[i] && is_spec(state_q[i])) begin
        st_m[i]   = (state_q[i] == ST_SPEC_RDY) ? ST_RDY : ST_RUN;
        comp_d[i] = 1'b1;
      end
    end
    imiss_d = imiss_n;
    other_d = (other_n & ~wake_ok) | kill_ok;
    stb_d   = stb_n;
  end

  // Round-robin selection over the post-rule states
  always_comb begin
    run_any = 1'b0;
    run_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (is_run(st_m[i])) begin
        run_any = 1'b1;
        run_idx = 2'(i);
      end
      // The running thread competes as its ready counterpart, which is why
      // the scan order ends on last itself.
      cand_rdy[i]  = bus.thr_en[i] && ((st_m[i] == ST_RDY) || (st_m[i] == ST_RUN));
      cand_spec[i] = bus.thr_en[i] && is_spec(st_m[i]);
    end
    keep = run_any && bus.thr_en[run_idx] && !bus.switch_req;

    found = 1'b0;
    pick  = last_q;
    idx   = last_q;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && cand_rdy[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && cand_spec[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    last_d = last_q;
    for (int unsigned i = 0; i < 4; i++) begin
      state_d[i] = st_m[i];
    end
    if (!bus.stallreq && !keep) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_m[i] == ST_RUN) begin
          state_d[i] = ST_RDY;
        end else if (st_m[i] == ST_SPEC_RUN) begin
          state_d[i] = ST_SPEC_RDY;
        end
      end
      if (found) begin
        state_d[pick] = cand_rdy[pick] ? ST_RUN : ST_SPEC_RUN;
        last_d        = pick;
      end
    end

    for (int unsigned i = 0; i < 4; i++) begin
      sel_d[i] = is_run(state_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      imiss_q <= '0;
      other_q <= '0;
      stb_q   <= '0;
      comp_q  <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= ST_RDY;
      end
    end else begin
      imiss_q <= imiss_d;
      other_q <= other_d;
      stb_q   <= stb_d;
      comp_q  <= comp_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      for (int unsigned i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  assign bus.wm_imiss    = imiss_q;
  assign bus.wm_other    = other_q;
  assign bus.wm_stbwait  = stb_q;
  assign bus.thr_state0  = state_q[0];
  assign bus.thr_state1  = state_q[1];
  assign bus.thr_state2  = state_q[2];
  assign bus.thr_state3  = state_q[3];
  assign bus.thr_sel     = sel_q;
  assign bus.thr_sel_vld = |sel_q;
  assign bus.completion  = comp_q;

endmodule
